// File: rtl/cpu_run_ctrl_pkg.sv
// Package: cpu_ctrl_pkg
// Shared types and constants for the run/step/halt sequencer.
//   ctrl_state_t : sequencer state, also exported on the debug LED port
//   BOOT_CYCLES  : length of the boot sequence (mem[0] read settle + PC load)
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    BOOT = 3'd1,
    RUN  = 3'd2,
    STEP = 3'd3,
    HALT = 3'd4
  } ctrl_state_t;

  localparam int BOOT_CYCLES = 2;

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// Interface: cpu_run_ctrl_if
// Control handshake between the run sequencer and the CPU datapath.
//   ins_recognized : decoder -> ctrl, current instruction is a legal opcode
//   waiting        : ctrl -> cpu/LEDs, sequencer idle awaiting first press
//   pc_clear       : ctrl -> cpu, 1-cycle PC <= 0
//   boot_load      : ctrl -> cpu, 1-cycle PC <= mem[0]
//   step_en        : ctrl -> cpu, 1-cycle commit of current instruction
//   halted, blink  : ctrl -> LEDs, halt indication and blink phase
//   state          : ctrl -> debug LEDs
// Modports: master = sequencer side, slave = CPU side.
interface cpu_run_ctrl_if;
  import cpu_ctrl_pkg::*;

  logic        ins_recognized;
  logic        waiting;
  logic        pc_clear;
  logic        boot_load;
  logic        step_en;
  logic        halted;
  logic        blink;
  ctrl_state_t state;

  modport master (
    input  ins_recognized,
    output waiting, pc_clear, boot_load, step_en, halted, blink, state
  );

  modport slave (
    output ins_recognized,
    input  waiting, pc_clear, boot_load, step_en, halted, blink, state
  );

endinterface

// File: rtl/cpu_run_ctrl_key_debounce.sv
// Module: key_debounce
// Two-flop synchronizer, stability counter and rising-edge pulse for one
// (already OR-combined, active-high) key level.
//   clk, rst : clock, synchronous active-high reset
//   raw      : asynchronous key level, 1 = pressed
//   level    : debounced level, 0 (not pressed) after reset
//   press    : 1-cycle pulse on the debounced 0->1 edge
// The debounced level flips after DEBOUNCE_CYC consecutive synchronized
// samples that differ from it; any agreeing sample restarts the count.
module key_debounce #(
  parameter int DEBOUNCE_CYC = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int             CW   = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CW-1:0]  LAST = CW'(DEBOUNCE_CYC - 1);

  logic          s1, s2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      level <= 1'b0;
      press <= 1'b0;
      cnt   <= '0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      press <= 1'b0;
      if (s2 != level) begin
        if (cnt == LAST) begin
          level <= s2;
          press <= s2;   // only the 0->1 transition produces a pulse
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Module: cpu_run_ctrl
// Run/step/halt sequencer for the 16-bit demo CPU. Waits in IDLE for the
// first debounced key press, boots (PC <= mem[0]), then commits one
// instruction every TICK_DIV cycles. An unrecognized opcode halts the
// sequencer (the faulting instruction still commits); a key press in HALT
// clears PC and reboots.
//   clk, rst   : clock, synchronous active-high reset
//   key_n[3:0] : push keys, active-low, asynchronous
//   step_mode  : single-step switch (used only with the macro below)
//   bus        : cpu_run_ctrl_if.master control handshake
// Optional feature: define CPU_RUN_CTRL_SINGLE_STEP_EN to enable the STEP
// state (key-driven single stepping selected by step_mode).
module cpu_run_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int TICK_DIV     = 67108864,
  parameter int DEBOUNCE_CYC = 500000,
  parameter int BLINK_BIT    = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    key_n,
  input  logic          step_mode,
  cpu_run_ctrl_if.master bus
);

  localparam int            TW    = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TLAST = TW'(TICK_DIV - 1);
  localparam logic [TW-1:0] TPRE  = TW'(TICK_DIV - 2);
  localparam int            BW    = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam logic [BW-1:0] BLAST = BW'(BOOT_CYCLES - 1);

  ctrl_state_t        state;
  logic [TW-1:0]      tick_cnt;
  logic [BW-1:0]      boot_ph;
  logic [BLINK_BIT:0] blink_cnt, blink_inc;
  logic               waiting, boot_load, step_en, halted, blink;
  logic               key_press, level_unused;
  logic               step_sel;

`ifdef CPU_RUN_CTRL_SINGLE_STEP_EN
  assign step_sel = step_mode;
`else
  logic step_mode_unused;
  assign step_mode_unused = step_mode;
  assign step_sel         = 1'b0;   // STEP is never entered
`endif

  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key (
    .clk   (clk),
    .rst   (rst),
    .raw   (|(~key_n)),
    .level (level_unused),
    .press (key_press)
  );

  assign blink_inc = blink_cnt + 1'b1;

  // Pulses are registered: each is set on the edge entering the cycle in
  // which it is valid, and cleared by default on every other edge.
  // step_en is high in the commit cycle, so the halt check looks at the
  // registered step_en together with the live ins_recognized.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      waiting   <= 1'b1;
      boot_load <= 1'b0;
      step_en   <= 1'b0;
      halted    <= 1'b0;
      blink     <= 1'b0;
      tick_cnt  <= '0;
      boot_ph   <= '0;
      blink_cnt <= '0;
    end else begin
      boot_load <= 1'b0;
      step_en   <= 1'b0;
      blink_cnt <= blink_inc;
      case (state)
        IDLE: begin
          if (key_press) begin
            state   <= BOOT;
            waiting <= 1'b0;
            boot_ph <= '0;
          end
        end
        BOOT: begin
          if (boot_ph != BLAST) begin
            boot_ph   <= boot_ph + 1'b1;
            boot_load <= (BW'(boot_ph + 1'b1) == BLAST);
          end else begin
            tick_cnt <= '0;
            state    <= step_sel ? STEP : RUN;
          end
        end
        RUN: begin
          if (step_en && !bus.ins_recognized) begin
            state     <= HALT;
            halted    <= 1'b1;
            blink     <= 1'b0;
            blink_cnt <= '0;
            tick_cnt  <= '0;
          end else if (step_sel) begin
            state    <= STEP;
            tick_cnt <= '0;
          end else begin
            tick_cnt <= (tick_cnt == TLAST) ? '0 : tick_cnt + 1'b1;
            step_en  <= (tick_cnt == TPRE);
          end
        end
        STEP: begin
          if (step_en && !bus.ins_recognized) begin
            state     <= HALT;
            halted    <= 1'b1;
            blink     <= 1'b0;
            blink_cnt <= '0;
          end else if (!step_sel) begin
            state    <= RUN;      // a press in this cycle is dropped
            tick_cnt <= '0;
          end else begin
            step_en <= key_press;
          end
        end
        HALT: begin
          if (key_press) begin
            state   <= BOOT;
            halted  <= 1'b0;
            blink   <= 1'b0;
            boot_ph <= '0;
          end else begin
            blink <= blink_inc[BLINK_BIT];
          end
        end
        default: begin
          state   <= IDLE;
          waiting <= 1'b1;
          halted  <= 1'b0;
          blink   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.waiting   = waiting;
  assign bus.boot_load = boot_load;
  assign bus.step_en   = step_en;
  assign bus.halted    = halted;
  assign bus.blink     = blink;
  assign bus.state     = state;
  // pc_clear shares the press cycle that moves HALT -> BOOT
  assign bus.pc_clear  = halted & key_press;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
module tb_cpu_run_ctrl;
  import cpu_ctrl_pkg::*;

  localparam int TD = 4;
  localparam int DC = 3;
  localparam int BB = 2;
`ifdef CPU_RUN_CTRL_SINGLE_STEP_EN
  localparam bit SS = 1'b1;
`else
  localparam bit SS = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] key_n = 4'hF;
  logic       step_mode = 1'b0;

  cpu_run_ctrl_if bus ();

  cpu_run_ctrl #(.TICK_DIV(TD), .DEBOUNCE_CYC(DC), .BLINK_BIT(BB)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_n     (key_n),
    .step_mode (step_mode),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int obs_step = 0;
  int obs_boot = 0;

  // Reference model: state plus "age in state" counters; pulse timing is
  // derived from ages with modulo arithmetic.
  ctrl_state_t m_st = IDLE;
  int  m_boot_age = 0, m_run_age = 0, m_halt_age = 0;
  bit  m_pend = 0;
  bit  m_hist1 = 0, m_hist2 = 0;   // key level seen 1 and 2 edges ago
  bit  m_lvl = 0, m_prs = 0;
  int  m_diff = 0;

  function automatic bit m_step();
    return (m_st == RUN && (m_run_age % TD) == TD - 1) || (m_st == STEP && m_pend);
  endfunction

  task automatic model_step();
    bit any, cur_step, ins;
    any      = (key_n != 4'hF);
    ins      = bus.ins_recognized;
    cur_step = m_step();
    if (rst) begin
      m_st = IDLE; m_boot_age = 0; m_run_age = 0; m_halt_age = 0; m_pend = 0;
      m_hist1 = 0; m_hist2 = 0; m_lvl = 0; m_prs = 0; m_diff = 0;
      return;
    end
    case (m_st)
      IDLE: if (m_prs) begin m_st = BOOT; m_boot_age = 0; end
      BOOT: if (m_boot_age < 1) m_boot_age++;
            else begin m_st = (SS && step_mode) ? STEP : RUN; m_run_age = 0; m_pend = 0; end
      RUN:  if (cur_step && !ins) begin m_st = HALT; m_halt_age = 0; end
            else if (SS && step_mode) begin m_st = STEP; m_pend = 0; end
            else m_run_age++;
      STEP: if (cur_step && !ins) begin m_st = HALT; m_halt_age = 0; m_pend = 0; end
            else if (!step_mode) begin m_st = RUN; m_run_age = 0; m_pend = 0; end
            else m_pend = m_prs;
      HALT: if (m_prs) begin m_st = BOOT; m_boot_age = 0; end
            else m_halt_age++;
      default: m_st = IDLE;
    endcase
    // debounce: level flips after DC consecutive differing synchronized samples
    m_prs = 0;
    if (m_hist2 != m_lvl) begin
      m_diff++;
      if (m_diff == DC) begin m_lvl = m_hist2; m_prs = m_hist2; m_diff = 0; end
    end else m_diff = 0;
    m_hist2 = m_hist1;
    m_hist1 = any;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
    end
  endtask

  task automatic check_out();
    chk("state",     32'(bus.state),     32'(m_st));
    chk("waiting",   32'(bus.waiting),   32'(m_st == IDLE));
    chk("boot_load", 32'(bus.boot_load), 32'(m_st == BOOT && m_boot_age == 1));
    chk("step_en",   32'(bus.step_en),   32'(m_step()));
    chk("halted",    32'(bus.halted),    32'(m_st == HALT));
    chk("blink",     32'(bus.blink),     32'(m_st == HALT && ((m_halt_age >> BB) & 1) == 1));
    chk("pc_clear",  32'(bus.pc_clear),  32'(m_st == HALT && m_prs));
    if (bus.step_en)   obs_step++;
    if (bus.boot_load) obs_boot++;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_out();
  endtask

  typedef struct {
    logic        r;
    logic [3:0]  k;
    logic        ins;
    int          n;
    ctrl_state_t st;
    logic        w;
    logic        h;
  } vec_t;
  vec_t tbl [11];

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int first;
    int hold;
    bus.ins_recognized = 1'b1;

    tbl[0]  = '{1'b1, 4'hF, 1'b1,   2, IDLE, 1'b1, 1'b0};
    tbl[1]  = '{1'b0, 4'hF, 1'b1, 100, IDLE, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 4'hE, 1'b1,   6, BOOT, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 4'hE, 1'b1,   2, RUN,  1'b0, 1'b0};
    tbl[4]  = '{1'b0, 4'hF, 1'b1,  20, RUN,  1'b0, 1'b0};
    tbl[5]  = '{1'b0, 4'hF, 1'b0,   3, RUN,  1'b0, 1'b0};
    tbl[6]  = '{1'b0, 4'hF, 1'b0,   1, HALT, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 4'hF, 1'b1,  20, HALT, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 4'h7, 1'b1,   5, HALT, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 4'h7, 1'b1,   1, BOOT, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 4'hF, 1'b1,   2, RUN,  1'b0, 1'b0};

    for (int i = 0; i < 11; i++) begin
      rst = tbl[i].r; key_n = tbl[i].k; bus.ins_recognized = tbl[i].ins;
      repeat (tbl[i].n) cyc();
      chk($sformatf("vec%0d_state", i),   32'(bus.state),   32'(tbl[i].st));
      chk($sformatf("vec%0d_waiting", i), 32'(bus.waiting), 32'(tbl[i].w));
      chk($sformatf("vec%0d_halted", i),  32'(bus.halted),  32'(tbl[i].h));
    end

    // bouncing key (2-cycle toggles) never debounces into a press
    rst = 1'b1; key_n = 4'hF; cyc(); rst = 1'b0; repeat (10) cyc();
    for (int i = 0; i < 20; i++) begin
      key_n = ((i / 2) % 2 == 0) ? 4'hB : 4'hF;
      cyc();
    end
    key_n = 4'hF; repeat (5) cyc();
    chk("bounce_idle", 32'(bus.state), 32'(IDLE));

    // reset one cycle before a due commit (cnt=2)
    key_n = 4'hE; repeat (8) cyc();
    key_n = 4'hF; repeat (2) cyc();
    rst = 1'b1; cyc();
    chk("midrun_rst_state",   32'(bus.state),   32'(IDLE));
    chk("midrun_rst_waiting", 32'(bus.waiting), 32'd1);
    chk("midrun_rst_step",    32'(bus.step_en), 32'd0);
    rst = 1'b0; obs_step = 0; repeat (8) cyc();
    chk("midrun_no_step", 32'(obs_step), 32'd0);
    chk("midrun_idle",    32'(bus.state), 32'(IDLE));

    // key held through reset release gives exactly one press / one boot
    rst = 1'b1; key_n = 4'hE; repeat (3) cyc();
    rst = 1'b0; obs_boot = 0; repeat (12) cyc();
    key_n = 4'hF; repeat (20) cyc();
    chk("held_rst_boots", 32'(obs_boot),  32'd1);
    chk("held_rst_run",   32'(bus.state), 32'(RUN));

`ifdef CPU_RUN_CTRL_SINGLE_STEP_EN
    rst = 1'b1; cyc(); rst = 1'b0; step_mode = 1'b1;
    key_n = 4'hE; repeat (8) cyc();
    chk("ss_boot_to_step", 32'(bus.state), 32'(STEP));
    key_n = 4'hF; repeat (10) cyc();
    obs_step = 0;
    for (int p = 0; p < 3; p++) begin
      key_n = 4'hD; repeat (6) cyc();
      key_n = 4'hF; repeat (8) cyc();
    end
    chk("ss_three_steps", 32'(obs_step),  32'd3);
    chk("ss_still_step",  32'(bus.state), 32'(STEP));
    step_mode = 1'b0; first = 0;
    for (int i = 1; i <= 8; i++) begin
      cyc();
      if (bus.step_en && first == 0) first = i;
    end
    chk("ss_run_first_step", 32'(first), 32'd4);
`endif

    // randomized traffic against the model
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold == 0) begin
        key_n = 4'hF;
        if ($urandom_range(0, 2) == 0) key_n[$urandom_range(0, 3)] = 1'b0;
        hold = $urandom_range(1, 10);
      end
      hold--;
      rst = ($urandom_range(0, 299) == 0);
      bus.ins_recognized = ($urandom_range(0, 5) != 0);
      if ($urandom_range(0, 40) == 0) step_mode = ~step_mode;
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
